// File: rtl/i2c_tb_pkg.sv
// Shared types for the I2C bench stream plumbing: destination encoding and count.
package i2c_tb_pkg;

    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_M1   = 3'd1,
        DST_M2   = 3'd2,
        DST_S1   = 3'd3,
        DST_S2   = 3'd4,
        DST_S3   = 3'd5
    } dest_e;

    localparam int NUM_DEST = 5;

    function automatic logic dest_valid(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'(NUM_DEST));
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream holding register; full throughput when the sink keeps ready high.
module axis_reg_slice
    import i2c_tb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  dest_e                 i_dest,
    input  logic                  i_out_ready,
    output logic                  o_full,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output dest_e                 o_dest,
    output logic                  o_in_ready
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    dest_e                 r_dest;

    // A load always wins over a drain, so a simultaneous drain+load keeps full set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_dest <= DST_NONE;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
            r_dest <= i_dest;
        end else if (r_full && i_out_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_full     = r_full;
    assign o_data     = r_data;
    assign o_last     = r_last;
    assign o_dest     = r_dest;
    assign o_in_ready = !r_full || i_out_ready;

endmodule

// File: rtl/mux_data_gen.sv
// 1-to-5 AXI-Stream router: destination chosen from sel on a packet's first beat and held to tlast.
module mux_data_gen
    import i2c_tb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            sel,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    input  logic                  tlast,
    output logic                  tready,
    input  logic                  tready_m1,
    input  logic                  tready_m2,
    input  logic                  tready_s1,
    input  logic                  tready_s2,
    input  logic                  tready_s3,
    output logic [DATA_WIDTH-1:0] tdata_m1,
    output logic [DATA_WIDTH-1:0] tdata_m2,
    output logic [DATA_WIDTH-1:0] tdata_s1,
    output logic [DATA_WIDTH-1:0] tdata_s2,
    output logic [DATA_WIDTH-1:0] tdata_s3,
    output logic                  tvalid_m1,
    output logic                  tvalid_m2,
    output logic                  tvalid_s1,
    output logic                  tvalid_s2,
    output logic                  tvalid_s3,
    output logic                  tlast_m1,
    output logic                  tlast_m2,
    output logic                  tlast_s1,
    output logic                  tlast_s2,
    output logic                  tlast_s3
);

    logic                  r_open;
    dest_e                 r_dest_lock;
    dest_e                 w_dest;
    logic                  w_dest_ok;
    logic                  w_accept;
    logic                  w_out_ready;
    logic                  w_full;
    logic                  w_last;
    logic                  w_in_ready;
    logic [DATA_WIDTH-1:0] w_data;
    dest_e                 w_held_dest;

    assign w_dest    = r_open ? r_dest_lock : dest_e'(sel);
    assign w_dest_ok = dest_valid(w_dest);
    assign tready    = !rst && w_dest_ok && w_in_ready;
    assign w_accept  = tvalid && tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open      <= 1'b0;
            r_dest_lock <= DST_NONE;
        end else if (w_accept) begin
            r_open      <= !tlast;
            r_dest_lock <= w_dest;
        end
    end

    // Drain uses the ready of the beat being held, which may belong to the previous packet.
    always_comb begin
        w_out_ready = 1'b0;
        case (w_held_dest)
            DST_M1:  w_out_ready = tready_m1;
            DST_M2:  w_out_ready = tready_m2;
            DST_S1:  w_out_ready = tready_s1;
            DST_S2:  w_out_ready = tready_s2;
            DST_S3:  w_out_ready = tready_s3;
            default: w_out_ready = 1'b0;
        endcase
    end

    axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_data      (tdata),
        .i_last      (tlast),
        .i_dest      (w_dest),
        .i_out_ready (w_out_ready),
        .o_full      (w_full),
        .o_data      (w_data),
        .o_last      (w_last),
        .o_dest      (w_held_dest),
        .o_in_ready  (w_in_ready)
    );

    always_comb begin
        tvalid_m1 = 1'b0; tdata_m1 = '0; tlast_m1 = 1'b0;
        tvalid_m2 = 1'b0; tdata_m2 = '0; tlast_m2 = 1'b0;
        tvalid_s1 = 1'b0; tdata_s1 = '0; tlast_s1 = 1'b0;
        tvalid_s2 = 1'b0; tdata_s2 = '0; tlast_s2 = 1'b0;
        tvalid_s3 = 1'b0; tdata_s3 = '0; tlast_s3 = 1'b0;
        case (w_held_dest)
            DST_M1:  begin tvalid_m1 = w_full; tdata_m1 = w_data; tlast_m1 = w_last; end
            DST_M2:  begin tvalid_m2 = w_full; tdata_m2 = w_data; tlast_m2 = w_last; end
            DST_S1:  begin tvalid_s1 = w_full; tdata_s1 = w_data; tlast_s1 = w_last; end
            DST_S2:  begin tvalid_s2 = w_full; tdata_s2 = w_data; tlast_s2 = w_last; end
            DST_S3:  begin tvalid_s3 = w_full; tdata_s3 = w_data; tlast_s3 = w_last; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mux_data_gen.sv
// Scoreboard bench for mux_data_gen: directed packets from the test plan plus randomized traffic.
module tb_mux_data_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;
    logic [5:1] rdy;
    logic [7:0] dat_a [1:5];
    logic       vld_a [1:5];
    logic       lst_a [1:5];

    always #5 clk = ~clk;

    mux_data_gen #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tlast     (tlast),
        .tready    (tready),
        .tready_m1 (rdy[1]),
        .tready_m2 (rdy[2]),
        .tready_s1 (rdy[3]),
        .tready_s2 (rdy[4]),
        .tready_s3 (rdy[5]),
        .tdata_m1  (dat_a[1]),
        .tdata_m2  (dat_a[2]),
        .tdata_s1  (dat_a[3]),
        .tdata_s2  (dat_a[4]),
        .tdata_s3  (dat_a[5]),
        .tvalid_m1 (vld_a[1]),
        .tvalid_m2 (vld_a[2]),
        .tvalid_s1 (vld_a[3]),
        .tvalid_s2 (vld_a[4]),
        .tvalid_s3 (vld_a[5]),
        .tlast_m1  (lst_a[1]),
        .tlast_m2  (lst_a[2]),
        .tlast_s1  (lst_a[3]),
        .tlast_s2  (lst_a[4]),
        .tlast_s3  (lst_a[5])
    );

    typedef struct {
        int         dest;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q [$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    m_open      = 1'b0;
    int    m_lock      = 0;
    bit    chk_zero    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int    eff;
        int    nvld;
        bit    exp_rdy;
        beat_t h;
        beat_t b;
        if (rst) begin
            chk("tready_in_reset", 32'(tready), 32'd0);
            exp_q.delete();
            m_open   = 1'b0;
            chk_zero = 1'b1;
        end else begin
            if (chk_zero) begin
                for (int d = 1; d <= 5; d++) begin
                    chk("post_reset_valid", 32'(vld_a[d]), 32'd0);
                    chk("post_reset_data",  32'(dat_a[d]), 32'd0);
                    chk("post_reset_last",  32'(lst_a[d]), 32'd0);
                end
                chk_zero = 1'b0;
            end
            eff     = m_open ? m_lock : int'(sel);
            exp_rdy = (eff >= 1 && eff <= 5) &&
                      (exp_q.size() == 0 || rdy[exp_q[0].dest] == 1'b1);
            chk("src_tready", 32'(tready), 32'(exp_rdy));
            nvld = 0;
            for (int d = 1; d <= 5; d++) nvld += int'(vld_a[d]);
            if (exp_q.size() == 0) begin
                chk("idle_no_valid", 32'(nvld), 32'd0);
            end else begin
                h = exp_q[0];
                chk("dest_valid", 32'(vld_a[h.dest]), 32'd1);
                chk("one_valid",  32'(nvld), 32'd1);
                chk("dest_data",  32'(dat_a[h.dest]), 32'(h.data));
                chk("dest_last",  32'(lst_a[h.dest]), 32'(h.last));
                for (int d = 1; d <= 5; d++) begin
                    if (d != h.dest) begin
                        chk("other_data", 32'(dat_a[d]), 32'd0);
                        chk("other_last", 32'(lst_a[d]), 32'd0);
                    end
                end
                if (rdy[h.dest]) void'(exp_q.pop_front());
            end
            if (tvalid && tready) begin
                b.dest = eff;
                b.data = tdata;
                b.last = tlast;
                exp_q.push_back(b);
                m_lock = eff;
                m_open = !tlast;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic l);
        bit acc;
        acc    = 1'b0;
        sel    = 3'(s);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        step();
        tvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sel = '0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; rdy = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Route to m1, four beats back-to-back
        rdy = 5'b11111;
        send(1, 8'h11, 1'b0);
        send(1, 8'h22, 1'b0);
        send(1, 8'h33, 1'b0);
        send(1, 8'h44, 1'b1);
        step();

        // Backpressure on s1
        send(3, 8'hA5, 1'b0);
        rdy[3] = 1'b0;
        tvalid = 1'b1; tdata = 8'hB6; tlast = 1'b0;
        repeat (4) step();
        rdy[3] = 1'b1;
        send(3, 8'hB6, 1'b0);
        send(3, 8'hC7, 1'b1);
        step();

        // Mid-packet select change is ignored; next packet uses the new sel
        send(2, 8'h01, 1'b0);
        send(5, 8'h02, 1'b0);
        send(5, 8'h03, 1'b1);
        send(5, 8'h04, 1'b1);
        step();

        // Invalid select stalls the source until sel becomes valid
        sel = 3'd0; tvalid = 1'b1; tdata = 8'h5A; tlast = 1'b1;
        repeat (3) step();
        sel = 3'd7;
        repeat (2) step();
        send(4, 8'h5A, 1'b1);
        step();

        // Reset while a beat is held
        rdy[1] = 1'b0;
        send(1, 8'h10, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy = 5'b11111;
        step();
        send(4, 8'h20, 1'b1);
        step();

        // Back-to-back single-beat packets to different destinations
        send(4, 8'h01, 1'b1);
        send(5, 8'h02, 1'b1);
        step();

        // Randomized traffic, readies, selects and occasional reset
        for (int i = 0; i < 600; i++) begin
            rdy    = 5'($urandom);
            sel    = 3'($urandom_range(0, 7));
            tvalid = ($urandom_range(0, 3) != 0);
            tdata  = 8'($urandom);
            tlast  = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; tvalid = 1'b0; rdy = 5'b11111;

        begin
            bit drained;
            drained = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (exp_q.size() == 0) begin
                    drained = 1'b1;
                    break;
                end
            end
            if (!drained) chk("drain_timeout", 32'd0, 32'd1);
        end
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
